// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitting / receiving).
// Holds the frame state encoding, line-level constants and default sizes.
package serial_pkg;

   // Default character width and clocks per serial bit, shared by both ends.
   localparam int DEF_DATA_BITS  = 7;
   localparam int DEF_BIT_CYCLES = 16;

   // Line levels for the framing bits.
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Frame sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled, wraps on each bit.
// Ports: clk, reset (async, active-high), enable, bit_done (wrap pulse).
module bit_timer
   import serial_pkg::*;
#(
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic bit_done
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // High during the final clock of a bit, so the FSM moves on the wrap edge.
   assign bit_done = enable && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!enable || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/transmitting.sv
// Serial transmitter: start, DATA_BITS data bits LSB first, [parity], stop.
// Ports: clk, reset, data_in, load -> data_out, busy, char_sent.
// Define TX_PARITY_EN to include the even-parity bit after the data bits.
module transmitting
   import serial_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 load,
   output logic                 data_out,
   output logic                 busy,
   output logic                 char_sent
);

   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   state_t               state;
   logic [DATA_BITS-1:0] shift_q;
   logic [IW-1:0]        bit_idx;
   logic                 timer_en;
   logic                 bit_done;

`ifdef TX_PARITY_EN
   // Untouched copy of the character; parity never looks at live data_in.
   logic [DATA_BITS-1:0] char_q;
`endif

   assign timer_en = (state != IDLE);

   bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (timer_en),
      .bit_done(bit_done)
   );

   // data_out is registered and always set to the level of the bit being
   // entered, so the line only moves on bit boundaries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_idx   <= '0;
         data_out  <= STOP_BIT;
         busy      <= 1'b0;
         char_sent <= 1'b0;
`ifdef TX_PARITY_EN
         char_q    <= '0;
`endif
      end else begin
         char_sent <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load) begin
                  shift_q  <= data_in;
`ifdef TX_PARITY_EN
                  char_q   <= data_in;
`endif
                  state    <= START;
                  data_out <= START_BIT;
                  busy     <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  state    <= DATA;
                  bit_idx  <= '0;
                  data_out <= shift_q[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  shift_q <= shift_q >> 1;
                  if (bit_idx == LAST_BIT) begin
`ifdef TX_PARITY_EN
                     state    <= PARITY;
                     data_out <= ^char_q;
`else
                     state    <= STOP;
                     data_out <= STOP_BIT;
`endif
                  end else begin
                     bit_idx  <= bit_idx + 1'b1;
                     data_out <= shift_q[1];
                  end
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  state    <= STOP;
                  data_out <= STOP_BIT;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  state     <= IDLE;
                  data_out  <= STOP_BIT;
                  busy      <= 1'b0;
                  char_sent <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               data_out <= STOP_BIT;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmitting.sv
// Testbench for transmitting: cycle-exact frame checks plus a line decoder
// feeding a scoreboard of expected characters.
module tb_transmitting;
   import serial_pkg::*;

   localparam int DB = DEF_DATA_BITS;
   localparam int BC = DEF_BIT_CYCLES;
`ifdef TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = DB + 2 + PAR;
   localparam int F  = NB * BC;

   typedef struct {
      logic [DB-1:0] data;
      logic          par;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          load;
   logic [DB-1:0] data_in;
   logic          data_out;
   logic          busy;
   logic          char_sent;

   int   checks = 0;
   int   errors = 0;
   int   cs_cnt = 0;
   int   frames_rx = 0;
   vec_t vecs[7];
   vec_t exp_q[$];

   transmitting dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .load     (load),
      .data_out (data_out),
      .busy     (busy),
      .char_sent(char_sent)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (char_sent === 1'b1) cs_cnt <= cs_cnt + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic exp_bit(vec_t v, int n);
      if (n == 0) return START_BIT;
      if (n <= DB) return v.data[n-1];
`ifdef TX_PARITY_EN
      if (n == DB + 1) return v.par;
`endif
      return STOP_BIT;
   endfunction

   // Entered at the negedge right after the accepting edge (k=0).
   // Checks {data_out,busy,char_sent} every clock up to stop_k, optionally
   // pulsing a rejected load at inj_k. Ends with the frame-end check.
   task automatic run_frame(vec_t v, int stop_k, int inj_k,
                            logic [DB-1:0] inj_d);
      for (int k = 0; k < stop_k; k++) begin
         chk($sformatf("frame %0h k=%0d", v.data, k),
             {data_out, busy, char_sent},
             {exp_bit(v, k / BC), 1'b1, 1'b0});
         if (k == inj_k) begin
            load    = 1'b1;
            data_in = inj_d;
         end else if (k == inj_k + 1) begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      if (stop_k == F)
         chk($sformatf("frame %0h end", v.data),
             {data_out, busy, char_sent}, 3'b101);
   endtask

   task automatic send(vec_t v);
      @(negedge clk);
      data_in = v.data;
      load    = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      load = 1'b0;
      run_frame(v, F, -10, '0);
   endtask

   task automatic idle_check(string name, int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(name, {data_out, busy, char_sent}, 3'b100);
      end
   endtask

   task automatic skip(int n, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (reset) begin
            hit = 1'b1;
            return;
         end
      end
   endtask

   // Mid-bit line decoder; abandons the frame if reset shows up.
   task automatic decode();
      logic [DB-1:0] d;
      logic          st;
      logic          sp;
      bit            hit;
      vec_t          e;
`ifdef TX_PARITY_EN
      logic          p;
`endif
      d = '0;
      skip(BC / 2, hit);
      if (hit) return;
      st = data_out;
      for (int i = 0; i < DB; i++) begin
         skip(BC, hit);
         if (hit) return;
         d[i] = data_out;
      end
`ifdef TX_PARITY_EN
      skip(BC, hit);
      if (hit) return;
      p = data_out;
`endif
      skip(BC, hit);
      if (hit) return;
      sp = data_out;
      frames_rx++;
      chk("scoreboard has entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("rx start", st, START_BIT);
      chk("rx data", d, e.data);
`ifdef TX_PARITY_EN
      chk("rx parity", p, e.par);
`endif
      chk("rx stop", sp, STOP_BIT);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && data_out === 1'b0) decode();
      end
   end

   initial begin
      int   cs0;
      vec_t v4b;
      vec_t v30;
      vecs[0] = '{7'h4B, 1'b0};
      vecs[1] = '{7'h01, 1'b1};
      vecs[2] = '{7'h00, 1'b0};
      vecs[3] = '{7'h7F, 1'b1};
      vecs[4] = '{7'h30, 1'b0};
      vecs[5] = '{7'h55, 1'b0};
      vecs[6] = '{7'h2A, 1'b1};
      v4b = vecs[0];
      v30 = vecs[4];

      reset   = 1'b0;
      load    = 1'b0;
      data_in = '0;
      #2 reset = 1'b1;
      #1 chk("reset async", {data_out, busy, char_sent}, 3'b100);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle_check("idle after reset", 20);

      // Table of single frames.
      for (int i = 0; i < 7; i++) send(vecs[i]);
      @(negedge clk);
      chk("char_sent count table", cs_cnt, 7);

      // Load while busy must be ignored.
      cs0 = cs_cnt;
      @(negedge clk);
      data_in = v4b.data;
      load    = 1'b1;
      exp_q.push_back(v4b);
      @(negedge clk);
      load = 1'b0;
      run_frame(v4b, F, 50, 7'h7F);
      idle_check("idle after reject", 40);
      chk("char_sent count reject", cs_cnt - cs0, 1);

      // Load held high: back-to-back frames, data_in changed mid-frame.
      cs0 = cs_cnt;
      @(negedge clk);
      data_in = v4b.data;
      load    = 1'b1;
      exp_q.push_back(v4b);
      exp_q.push_back(v30);
      @(negedge clk);
      data_in = v30.data;
      run_frame(v4b, F, -10, '0);
      @(negedge clk);
      load = 1'b0;
      run_frame(v30, F, -10, '0);
      idle_check("idle after b2b", 5);
      chk("char_sent count b2b", cs_cnt - cs0, 2);

      // Reset in the middle of a frame.
      cs0 = cs_cnt;
      @(negedge clk);
      data_in = v4b.data;
      load    = 1'b1;
      exp_q.push_back(v4b);
      @(negedge clk);
      load = 1'b0;
      run_frame(v4b, 70, -10, '0);
      #2 reset = 1'b1;
      #1 chk("abort async", {data_out, busy, char_sent}, 3'b100);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_check("idle after abort", 30);
      chk("char_sent count abort", cs_cnt - cs0, 0);
      send(v4b);

      idle_check("final idle", 5);
      chk("scoreboard drained", exp_q.size(), 0);
      chk("frames decoded", frames_rx, 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/transmitting.md
# transmitting

Serial UART-style transmitter: the sending end of the project's serial link, whose frames are consumed by the `receiving` block. It accepts one parallel character on a load strobe and shifts it out as a framed serial stream: start bit (0), DATA_BITS data bits LSB first, optional even-parity bit, stop bit (1). Each bit is held for BIT_CYCLES clocks. The block sits between the CPU's output port register and the serial line pin.

## Interface
- DATA_BITS, 7: character width in bits.
- BIT_CYCLES, 16: clocks per serial bit. Must be ≥2.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous and active-high.
- data_in  input  DATA_BITS  character to send; sampled only on the accepting edge.
- load  input  1  send request; accepted when high at a rising edge while busy==0.
- data_out  output  1  serial line; idle level 1.
- busy  output  1  high from the accepting edge until the end of the stop bit.
- char_sent  output  1  one-cycle pulse marking frame completion.

## Operation
- States:
  - IDLE: data_out=1. load=1 latches data_in into the shift register and goes to START.
  - START: data_out=0 for BIT_CYCLES clocks, then DATA.
  - DATA: data_out=shift[0] for BIT_CYCLES clocks per bit; shift right after each bit. After DATA_BITS bits, go to PARITY (or STOP when parity is compiled out).
  - PARITY: data_out = XOR of the latched character (even parity), held for BIT_CYCLES clocks.
  - STOP: data_out=1 for BIT_CYCLES clocks, then IDLE.
- Counters:
  - Cycle counter: $clog2(BIT_CYCLES) bits, counts 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary.
  - Bit index counter: $clog2(DATA_BITS+1) bits, cleared on entry to DATA.
- Parity is computed from the latched copy, never from live data_in.
- load while busy is ignored: no queuing, no frame corruption. data_in changes mid-frame have no effect.
- Reset outputs: data_out=1, busy=0, char_sent=0, state=IDLE, counters=0.
- Reset asserted mid-frame forces the line to 1 immediately and aborts the frame. No char_sent is issued.
- All outputs are registered; data_out is glitch-free.

## Timing
- Accepting edge T: after T, data_out=0 and busy=1.
- Bit n of the frame (start = bit 0) occupies edges T+n·BIT_CYCLES up to (but not including) T+(n+1)·BIT_CYCLES.
- Frame length F = (DATA_BITS+3)·BIT_CYCLES with parity (160 clocks at defaults), or (DATA_BITS+2)·BIT_CYCLES without.
- At edge T+F: busy=0, char_sent=1 for exactly one cycle, state=IDLE, data_out stays 1.
- load high at edge T+F (busy already 0 on the preceding cycle is not required): the request is not accepted; the earliest acceptance is edge T+F+1. Gap between frames is ≥1 idle clock of line-high.
- load held high continuously sends back-to-back frames with a period of F+1 clocks.

## Configuration
- TX_PARITY_EN:
  - Defined: the PARITY state is present and frames carry the even-parity bit. This is the required setting to interoperate with `receiving`.
  - Undefined: the PARITY state, parity logic, and one bit time are removed. STOP follows the last data bit directly.

## Structure
- Shared package `serial_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - START_BIT=0 and STOP_BIT=1 constants.
  - default DATA_BITS/BIT_CYCLES. The same values are used by `receiving`.
- One sub-module, `bit_timer`: holds the cycle counter. It takes clk, reset, and an enable (high in non-IDLE states), and emits a one-cycle bit_done pulse on the count wrap. The FSM, shift register, and parity stay in `transmitting`.

## Test plan
- Reset behaviour: assert reset asynchronously mid-cycle → data_out=1, busy=0, char_sent=0 immediately. After release, the line stays 1 with no load.
- Single frame: data_in=7'h4B, load pulse at T → line sequence 0,1,1,0,1,0,0,1,0,1, each bit exactly 16 clocks. char_sent pulses at T+160; busy spans T..T+159.
- Parity: data_in=7'h01 → parity bit 1; data_in=7'h00 → parity bit 0. With TX_PARITY_EN undefined → no parity bit, char_sent at T+144.
- Busy rejection: second load with 7'h7F at T+50 → first frame unaltered, no second frame, one char_sent only.
- Back-to-back: load held high with 7'h4B then 7'h30 → two correct frames, second start bit at T+161, char_sent at T+160 and T+321.
- Reset abort: reset at T+70 → line 1 at once, no char_sent. A fresh load after release sends a full correct frame.
